// File: rtl/nes_bus_pkg.sv
// nes_bus_pkg: system bus register addresses and sprite DMA state encoding
package nes_bus_pkg;
  localparam logic [15:0] OAM_DMA_REG  = 16'h4014;
  localparam logic [15:0] OAM_DATA_REG = 16'h2004;
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} dma_state_e;
endpackage

// File: rtl/oam_dma.sv
// oam_dma: sprite DMA that halts the CPU and copies one page to the PPU OAM data port
module oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] OAM_DMA_ADDR  = OAM_DMA_REG,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_REG,
  parameter int          COUNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_write,
  input  logic [7:0]  bus_d_in,
  output logic        ready,
  output logic [15:0] addr,
  output logic [7:0]  d_out,
  output logic        write,
  output logic        dma_active
);
  dma_state_e         state_q, state_d;
  logic               parity_q, parity_d;
  logic [COUNT_W-1:0] idx_q, idx_d;
  logic [7:0]         page_q, page_d, data_q, data_d;
  always_comb begin
    state_d  = state_q;
    parity_d = ~parity_q;
    idx_d    = idx_q;
    page_d   = page_q;
    data_d   = data_q;
    ready    = 1'b0;
    addr     = cpu_addr;
    d_out    = cpu_d_out;
    write    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        write = cpu_write;
        if (cpu_write && cpu_addr == OAM_DMA_ADDR) begin
          page_d  = cpu_d_out;
          idx_d   = '0;
          state_d = HALT;
        end
      end
      HALT:  state_d = parity_q ? READ : ALIGN;
      ALIGN: state_d = READ;
      READ: begin
        addr    = {page_q, 8'h00} | 16'(idx_q);
        d_out   = data_q;
        data_d  = bus_d_in;
        state_d = WRITE;
      end
      WRITE: begin
        addr    = OAM_DATA_ADDR;
        d_out   = data_q;
        write   = 1'b1;
        idx_d   = idx_q + 1'b1;
        state_d = &idx_q ? IDLE : READ;
      end
      default: state_d = IDLE;
    endcase
    dma_active = state_q != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      parity_q <= 1'b0;
      idx_q    <= '0;
      page_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      parity_q <= parity_d;
      idx_q    <= idx_d;
      page_q   <= page_d;
      data_q   <= data_d;
    end
  end
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed checks of passthrough, halt length, transfer data, reset abort and retrigger
module tb_oam_dma;
  logic        clk = 1'b0, reset = 1'b0, cpu_write = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_d_out = '0, bus_d_in;
  logic        ready, write, dma_active;
  logic [15:0] addr;
  logic [7:0]  d_out;
  logic        exp_par = 1'b0;
  int          n_chk = 0, n_fail = 0;
  oam_dma dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_d_out(cpu_d_out),
    .cpu_write(cpu_write), .bus_d_in(bus_d_in), .ready(ready), .addr(addr),
    .d_out(d_out), .write(write), .dma_active(dma_active)
  );
  always #5 clk = ~clk;
  assign bus_d_in = addr[7:0] ^ 8'h5A;
  always @(posedge clk) exp_par <= !reset ? 1'b0 : ~exp_par;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic trigger(input logic [7:0] pg);
    cpu_addr = 16'h4014; cpu_d_out = pg; cpu_write = 1'b1;
    #4;
    chk("trig_ready", ready, 1);
    chk("trig_pass", {addr, d_out, write}, {16'h4014, pg, 1'b1});
    cyc();
    cpu_addr = 16'h1111; cpu_write = 1'b0; cpu_d_out = 8'hEE;
  endtask
  task automatic run_dma(input logic [7:0] pg, input bit halt_odd, input bit stray);
    int low = 0, dummy = 0, nw = 0, nr = 0, bad_d = 0, bad_a = 0;
    logic [15:0] first_ra = '1, last_ra = '0;
    bit done = 0;
    while (exp_par != (halt_odd ? 1'b0 : 1'b1)) cyc();
    trigger(pg);
    for (int c = 0; c < 700 && !done; c++) begin
      if (stray && c == 50) begin cpu_addr = 16'h4014; cpu_d_out = 8'h07; cpu_write = 1'b1; end
      if (stray && c == 51) begin cpu_addr = 16'h1111; cpu_write = 1'b0; end
      #4;
      if (ready) done = 1;
      else begin
        low++;
        if (write) begin
          if (addr == 16'h2004) begin
            if (d_out != (nw[7:0] ^ 8'h5A)) bad_d++;
            nw++;
          end
        end else if (low <= 2 && addr == cpu_addr) dummy++;
        else begin
          if (nr == 0) first_ra = addr;
          last_ra = addr;
          if (addr != {pg, nr[7:0]}) bad_a++;
          nr++;
        end
      end
      cyc();
    end
    chk("dma_done", done, 1);
    chk("low_cycles", low, halt_odd ? 513 : 514);
    chk("dummy_cycles", dummy, halt_odd ? 1 : 2);
    chk("first_read", first_ra, {pg, 8'h00});
    chk("last_read", last_ra, {pg, 8'hFF});
    chk("read_count", nr, 256);
    chk("read_addr_errs", bad_a, 0);
    chk("write_count", nw, 256);
    chk("write_data_errs", bad_d, 0);
    cpu_addr = 16'h0BEE; cpu_d_out = 8'h77; cpu_write = 1'b1;
    #4;
    chk("post_pass", {ready, dma_active, addr, d_out, write}, {1'b1, 1'b0, 16'h0BEE, 8'h77, 1'b1});
    cyc();
    cpu_write = 1'b0;
  endtask
  initial begin
    int nw;
    bit hit;
    cpu_addr = 16'h1234; cpu_write = 1'b1; cpu_d_out = 8'h9C;
    #1;
    for (int i = 0; i < 2; i++) begin
      #4;
      chk("rst_ready", ready, 1);
      chk("rst_active", dma_active, 0);
      chk("rst_pass", {addr, write}, {16'h1234, 1'b1});
      cyc();
    end
    reset = 1'b1; cpu_write = 1'b0;
    cyc();
    run_dma(8'h02, 1, 0);
    run_dma(8'h02, 0, 0);
    cpu_addr = 16'h2004; cpu_d_out = 8'h33; cpu_write = 1'b1;
    #4;
    chk("ppu_wr_pass", {ready, addr, d_out, write}, {1'b1, 16'h2004, 8'h33, 1'b1});
    cyc();
    cpu_addr = 16'h4015; cpu_d_out = 8'h01;
    #4;
    chk("apu_wr_pass", {ready, addr, d_out, write}, {1'b1, 16'h4015, 8'h01, 1'b1});
    cyc();
    cpu_addr = 16'h8000; cpu_write = 1'b0;
    #4;
    chk("no_trigger", {ready, dma_active, addr, write}, {1'b1, 1'b0, 16'h8000, 1'b0});
    cyc();
    trigger(8'h01);
    hit = 0;
    for (int c = 0; c < 700 && !hit; c++) begin
      #4;
      if (!ready && !write && addr == 16'h0164) begin hit = 1; reset = 1'b0; end
      cyc();
    end
    chk("abort_reached", hit, 1);
    reset = 1'b1;
    #4;
    chk("abort_state", {ready, dma_active}, {1'b1, 1'b0});
    nw = 0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) #4;
      if (write && addr == 16'h2004) nw++;
      cyc();
    end
    chk("abort_no_writes", nw, 0);
    run_dma(8'h03, 1, 0);
    run_dma(8'hFF, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
